// File: rtl/define_state_pkg.sv
// Shared state and constant definitions for the PPM-to-SRAM writer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package define_state;

    // Writer FSM states.
    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_DATA,
        S_FLUSH,
        S_DONE
    } ppm_state_t;

    // A PPM header is three text lines; each ends in a line feed.
    localparam logic [7:0] LINE_FEED = 8'h0A;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DATA_W = 16;

endpackage

// File: rtl/ppm_idle_timer.sv
// Idle timer: counts enabled cycles since the last clear and flags the last one.
// Latency: expired rises TIMEOUT_CYCLES-1 enabled cycles after a clear.
// Backpressure: none; clear wins over enable, count holds at its terminal value.
// Ports: clk, reset (sync, active high), clear, enable -> expired.
module ppm_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            // Holding at LAST keeps expired asserted instead of wrapping.
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/ppm_sram_writer.sv
// Strips a 3-line PPM header from a UART byte stream and packs the pixel bytes into 16-bit SRAM words.
// Latency: a word is written the cycle after its second byte is accepted; Done follows an idle timeout.
// Backpressure: none; a byte may arrive every cycle, words past MAX_WORD_ADDR are dropped (Overflow).
// Ports: Clock_50, Reset (sync, active high), Start, Byte_data/Byte_valid in;
//        SRAM_address/SRAM_write_data/SRAM_we_n, Busy, Done, Overflow, Word_count out.
module ppm_sram_writer
    import define_state::*;
#(
    parameter int unsigned      TIMEOUT_CYCLES = 50000000,
    parameter logic [ADDR_W-1:0] MAX_WORD_ADDR = 18'h3FFFF
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Byte_data,
    input  logic              Byte_valid,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    output logic              Busy,
    output logic              Done,
    output logic              Overflow,
    output logic [ADDR_W-1:0] Word_count
);

    localparam logic [ADDR_W:0] WC_ONE = (ADDR_W + 1)'(1);

    ppm_state_t state, state_next;

    logic [1:0]        lf_cnt;
    logic              phase;       // 1: a high byte is held, waiting for its low byte
    logic [7:0]        high_byte;
    logic [ADDR_W:0]   word_cnt;    // one extra bit so a full SRAM does not wrap to 0
    logic              got_byte;    // a byte has arrived since Start; arms the timer

    logic              in_rx;
    logic              byte_ok;
    logic              timer_clear;
    logic              timer_enable;
    logic              timer_expired;
    logic              timeout;
    logic              wr_req;
    logic              wr_room;
    logic [DATA_W-1:0] wr_word;

    assign in_rx        = (state == S_HEADER) || (state == S_DATA);
    assign byte_ok      = in_rx && Byte_valid;
    assign timer_clear  = (state == S_IDLE) || byte_ok;
    assign timer_enable = in_rx && got_byte;
    // A byte in the expiry cycle restarts the timer instead of ending the transfer.
    assign timeout      = timer_expired && timer_enable && !Byte_valid;

    assign wr_req  = ((state == S_DATA) && Byte_valid && phase) || (state == S_FLUSH);
    assign wr_room = (word_cnt <= {1'b0, MAX_WORD_ADDR});
    assign wr_word = (state == S_FLUSH) ? {high_byte, 8'h00} : {high_byte, Byte_data};

    ppm_idle_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk     (Clock_50),
        .reset   (Reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_HEADER;
                end
            end
            S_HEADER: begin
                if (Byte_valid) begin
                    if ((Byte_data == LINE_FEED) && (lf_cnt == 2'd2)) begin
                        state_next = S_DATA;
                    end
                end else if (timeout) begin
                    state_next = S_DONE;
                end
            end
            S_DATA: begin
                if (timeout) begin
                    state_next = phase ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            lf_cnt          <= '0;
            phase           <= 1'b0;
            high_byte       <= '0;
            word_cnt        <= '0;
            got_byte        <= 1'b0;
            Overflow        <= 1'b0;
            SRAM_we_n       <= 1'b1;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
        end else begin
            SRAM_we_n <= 1'b1;

            if ((state == S_IDLE) && Start) begin
                lf_cnt   <= '0;
                phase    <= 1'b0;
                word_cnt <= '0;
                got_byte <= 1'b0;
                Overflow <= 1'b0;
            end

            if (byte_ok) begin
                got_byte <= 1'b1;
            end

            if ((state == S_HEADER) && Byte_valid && (Byte_data == LINE_FEED)) begin
                lf_cnt <= lf_cnt + 2'd1;
            end

            if ((state == S_DATA) && Byte_valid) begin
                phase <= ~phase;
                if (!phase) begin
                    high_byte <= Byte_data;
                end
            end

            if (state == S_FLUSH) begin
                phase <= 1'b0;
            end

            if (wr_req) begin
                if (wr_room) begin
                    SRAM_we_n       <= 1'b0;
                    SRAM_address    <= word_cnt[ADDR_W-1:0];
                    SRAM_write_data <= wr_word;
                    word_cnt        <= word_cnt + WC_ONE;
                end else begin
                    Overflow <= 1'b1;
                end
            end
        end
    end

    assign Busy       = (state != S_IDLE);
    assign Done       = (state == S_DONE);
    assign Word_count = word_cnt[ADDR_W] ? {ADDR_W{1'b1}} : word_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_ppm_sram_writer.sv
`timescale 1ns/1ps
module tb_ppm_sram_writer;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic [17:0] a_addr, s_addr, a_wc, s_wc;
    logic [15:0] a_data, s_data;
    logic        a_we_n, s_we_n, a_busy, s_busy, a_done, s_done, a_ovf, s_ovf;

    ppm_sram_writer #(.TIMEOUT_CYCLES(TO)) dut (
        .Clock_50(clk), .Reset(reset), .Start(start),
        .Byte_data(byte_data), .Byte_valid(byte_valid),
        .SRAM_address(a_addr), .SRAM_write_data(a_data), .SRAM_we_n(a_we_n),
        .Busy(a_busy), .Done(a_done), .Overflow(a_ovf), .Word_count(a_wc)
    );

    ppm_sram_writer #(.TIMEOUT_CYCLES(TO), .MAX_WORD_ADDR(18'd1)) dut_small (
        .Clock_50(clk), .Reset(reset), .Start(start),
        .Byte_data(byte_data), .Byte_valid(byte_valid),
        .SRAM_address(s_addr), .SRAM_write_data(s_data), .SRAM_we_n(s_we_n),
        .Busy(s_busy), .Done(s_done), .Overflow(s_ovf), .Word_count(s_wc)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          c;
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t  wr_a[$];
    wr_t  wr_s[$];
    int   done_a[$];
    int   done_s[$];
    int   cyc = 0;
    wr_t  mon;

    logic [7:0] hdr [11] = '{8'h50, 8'h36, 8'h0A, 8'h34, 8'h20, 8'h32,
                             8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};
    logic [7:0] data_q[$];
    int         acc_q[$];
    int         last_acc;
    int         n_tests = 0;
    int         n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write cycle and every Done cycle of both instances.
    always @(negedge clk) begin
        if (a_we_n === 1'b0) begin
            mon.c = cyc; mon.a = a_addr; mon.d = a_data;
            wr_a.push_back(mon);
        end
        if (s_we_n === 1'b0) begin
            mon.c = cyc; mon.a = s_addr; mon.d = s_data;
            wr_s.push_back(mon);
        end
        if (a_done === 1'b1) done_a.push_back(cyc);
        if (s_done === 1'b1) done_s.push_back(cyc);
    end

    task automatic idle(input int n);
        byte_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_data  = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        last_acc   = cyc;
    endtask

    task automatic start_transfer();
        wr_a.delete(); wr_s.delete(); done_a.delete(); done_s.delete(); acc_q.delete();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_header(input int gap_max);
        for (int i = 0; i < 11; i++) begin
            send_byte(hdr[i]);
            idle(int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic send_data(input int gap_max);
        for (int i = 0; i < data_q.size(); i++) begin
            send_byte(data_q[i]);
            acc_q.push_back(last_acc);
            if (i != data_q.size() - 1) idle(int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic wait_done(output bit ok);
        for (int i = 0; i < 100 && done_a.size() == 0; i++) idle(1);
        idle(3);
        ok = (done_a.size() != 0);
    endtask

    task automatic test_reset();
        logic [55:0] got_a, got_s;
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        idle(3);
        got_a = {a_we_n, a_busy, a_done, a_ovf, a_addr, a_data, a_wc};
        got_s = {s_we_n, s_busy, s_done, s_ovf, s_addr, s_data, s_wc};
        n_tests++;
        if (got_a !== {1'b1, 3'b000, 18'd0, 16'd0, 18'd0}) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", got_a, {1'b1, 3'b000, 18'd0, 16'd0, 18'd0});
        end
        n_tests++;
        if (got_s !== {1'b1, 3'b000, 18'd0, 16'd0, 18'd0}) begin
            n_fail++;
            $display("FAIL reset_s: got %h expected %h", got_s, {1'b1, 3'b000, 18'd0, 16'd0, 18'd0});
        end
        reset = 1'b0;
        idle(2);
    endtask

    // Fixed scenarios first (even, odd with flush, back-to-back), then random ones.
    task automatic test_transfers();
        int n, words, nexp_s, gap, ec, edone;
        bit ok;
        logic [15:0] ed;
        for (int it = 0; it < 9; it++) begin
            data_q.delete();
            case (it)
                0: begin data_q = '{8'h11, 8'h22, 8'h33, 8'h44}; gap = 3; end
                1: begin data_q = '{8'hAA, 8'hBB, 8'hCC}; gap = 3; end
                2: begin data_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; gap = 0; end
                default: begin
                    n = int'($urandom_range(12, 1));
                    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
                    gap = int'($urandom_range(6, 0));
                end
            endcase
            n      = data_q.size();
            words  = (n + 1) / 2;
            nexp_s = (words < 2) ? words : 2;

            start_transfer();
            send_header(2);
            n_tests++;
            if (a_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy[%0d]: got %b expected 1", it, a_busy);
            end
            send_data(gap);
            wait_done(ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL done_timeout[%0d]: got no Done expected Done", it);
            end

            n_tests++;
            if (wr_a.size() != words) begin
                n_fail++;
                $display("FAIL wr_count_a[%0d]: got %0d expected %0d", it, wr_a.size(), words);
            end
            n_tests++;
            if (wr_s.size() != nexp_s) begin
                n_fail++;
                $display("FAIL wr_count_s[%0d]: got %0d expected %0d", it, wr_s.size(), nexp_s);
            end
            for (int k = 0; k < words; k++) begin
                ed = {data_q[2*k], (2*k+1 < n) ? data_q[2*k+1] : 8'h00};
                ec = (2*k+1 < n) ? acc_q[2*k+1] : last_acc + 17;
                if (k < wr_a.size()) begin
                    n_tests++;
                    if (wr_a[k].c !== ec || wr_a[k].a !== 18'(k) || wr_a[k].d !== ed) begin
                        n_fail++;
                        $display("FAIL wr_a[%0d][%0d]: got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                                 it, k, wr_a[k].c, wr_a[k].a, wr_a[k].d, ec, 18'(k), ed);
                    end
                end
                if (k < wr_s.size() && k < nexp_s) begin
                    n_tests++;
                    if (wr_s[k].c !== ec || wr_s[k].a !== 18'(k) || wr_s[k].d !== ed) begin
                        n_fail++;
                        $display("FAIL wr_s[%0d][%0d]: got cyc %0d addr %h data %h expected cyc %0d addr %h data %h",
                                 it, k, wr_s[k].c, wr_s[k].a, wr_s[k].d, ec, 18'(k), ed);
                    end
                end
            end

            edone = last_acc + ((n % 2 == 1) ? 17 : 16);
            n_tests++;
            if (done_a.size() != 1 || done_s.size() != 1) begin
                n_fail++;
                $display("FAIL done_pulses[%0d]: got %0d/%0d expected 1/1", it, done_a.size(), done_s.size());
            end else if (done_a[0] != edone || done_s[0] != edone) begin
                n_fail++;
                $display("FAIL done_cycle[%0d]: got %0d/%0d expected %0d", it, done_a[0], done_s[0], edone);
            end

            n_tests++;
            if ({a_wc, a_ovf, a_busy} !== {18'(words), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL status_a[%0d]: got wc %0d ovf %b busy %b expected wc %0d ovf 0 busy 0",
                         it, a_wc, a_ovf, a_busy, words);
            end
            n_tests++;
            if ({s_wc, s_ovf} !== {18'(nexp_s), (words > 2)}) begin
                n_fail++;
                $display("FAIL status_s[%0d]: got wc %0d ovf %b expected wc %0d ovf %b",
                         it, s_wc, s_ovf, nexp_s, (words > 2));
            end
        end
    endtask

    task automatic test_timeout_race();
        logic [7:0] b0, b1;
        int first, second;
        bit ok;
        b0 = 8'($urandom); b1 = 8'($urandom);
        start_transfer();
        send_header(0);
        send_byte(b0);
        first = last_acc;
        idle(TO - 1);
        n_tests++;
        if (done_a.size() != 0) begin
            n_fail++;
            $display("FAIL race_early_done: got %0d pulses expected 0 (byte at %0d)", done_a.size(), first);
        end
        send_byte(b1);
        second = last_acc;
        wait_done(ok);
        n_tests++;
        if (!ok || done_a.size() != 1 || done_a[0] != second + 16) begin
            n_fail++;
            $display("FAIL race_done: got %0d pulses first at %0d expected 1 at %0d",
                     done_a.size(), (done_a.size() != 0) ? done_a[0] : -1, second + 16);
        end
        n_tests++;
        if (wr_a.size() != 1 || wr_a[0].c != second || wr_a[0].a !== 18'd0 || wr_a[0].d !== {b0, b1}) begin
            n_fail++;
            $display("FAIL race_write: got %0d writes expected 1 write %h at cyc %0d", wr_a.size(), {b0, b1}, second);
        end
    endtask

    task automatic test_start_ignored();
        logic [7:0] d [4];
        bit ok;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        // Bytes in idle, including line feeds, must not advance the header parser.
        send_byte(8'h0A); send_byte(8'h0A); send_byte(8'h0A); send_byte(8'h11); send_byte(8'h22);
        idle(2);
        start_transfer();
        send_header(1);
        send_byte(d[0]); send_byte(d[1]);
        start = 1'b1; idle(1); start = 1'b0;
        send_byte(d[2]); send_byte(d[3]);
        wait_done(ok);
        n_tests++;
        if (!ok || wr_a.size() != 2) begin
            n_fail++;
            $display("FAIL start_busy_count: got done %b writes %0d expected done 1 writes 2", ok, wr_a.size());
        end else if (wr_a[0].a !== 18'd0 || wr_a[0].d !== {d[0], d[1]} ||
                     wr_a[1].a !== 18'd1 || wr_a[1].d !== {d[2], d[3]}) begin
            n_fail++;
            $display("FAIL start_busy_data: got %h@%h %h@%h expected %h@0 %h@1",
                     wr_a[0].d, wr_a[0].a, wr_a[1].d, wr_a[1].a, {d[0], d[1]}, {d[2], d[3]});
        end
        n_tests++;
        if (a_wc !== 18'd2) begin
            n_fail++;
            $display("FAIL start_busy_wc: got %0d expected 2", a_wc);
        end
    endtask

    task automatic test_reset_mid();
        logic [55:0] got_a, got_s;
        data_q.delete();
        for (int i = 0; i < 3; i++) data_q.push_back(8'($urandom));
        start_transfer();
        send_header(1);
        send_data(1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        got_a = {a_we_n, a_busy, a_done, a_ovf, a_addr, a_data, a_wc};
        got_s = {s_we_n, s_busy, s_done, s_ovf, s_addr, s_data, s_wc};
        n_tests++;
        if (got_a !== {1'b1, 3'b000, 18'd0, 16'd0, 18'd0} || got_s !== {1'b1, 3'b000, 18'd0, 16'd0, 18'd0}) begin
            n_fail++;
            $display("FAIL mid_reset_values: got %h / %h expected %h", got_a, got_s, {1'b1, 3'b000, 18'd0, 16'd0, 18'd0});
        end
        reset = 1'b0;
        idle(40);
        n_tests++;
        if (wr_a.size() != 1 || wr_s.size() != 1) begin
            n_fail++;
            $display("FAIL mid_reset_writes: got %0d/%0d expected 1/1", wr_a.size(), wr_s.size());
        end
        n_tests++;
        if (done_a.size() != 0 || done_s.size() != 0 || a_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_done: got done %0d/%0d busy %b expected 0/0 busy 0",
                     done_a.size(), done_s.size(), a_busy);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        test_reset();
        test_transfers();
        test_timeout_race();
        test_start_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ppm_sram_writer.md
PPM_SRAM_WRITER -- requirements
Module: ppm_sram_writer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000000, idle cycles after the last received byte that end a transfer (1 s at 50 MHz).
REQ-002 Parameter MAX_WORD_ADDR, default 18'h3FFFF, highest SRAM word address the block writes.
REQ-003 Clock_50  in  1  single 50 MHz clock; all logic is on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Start  in  1  single-cycle pulse that arms a new transfer.
REQ-006 Byte_data  in  8  byte from the UART receiver.
REQ-007 Byte_valid  in  1  single-cycle strobe qualifying Byte_data; no backpressure.
REQ-008 SRAM_address  out  18  word write address.
REQ-009 SRAM_write_data  out  16  write word, {first byte, second byte}.
REQ-010 SRAM_we_n  out  1  active-low write enable.
REQ-011 Busy  out  1  high in every state except S_IDLE.
REQ-012 Done  out  1  single-cycle pulse marking the end of a transfer.
REQ-013 Overflow  out  1  sticky flag, set when data is dropped past MAX_WORD_ADDR.
REQ-014 Word_count  out  18  number of words written in the current transfer.

Function
REQ-015 States: S_IDLE, S_HEADER, S_DATA, S_FLUSH, S_DONE.
REQ-016 S_IDLE: Start -> S_HEADER; this clears the LF counter, byte phase, Word_count, timer and Overflow. Bytes received in S_IDLE are ignored.
REQ-017 S_HEADER: each valid byte equal to 8'h0A increments a 2-bit LF counter; the byte that raises the count to 3 moves the FSM to S_DATA. No header byte is written.
REQ-018 S_DATA, even phase: the valid byte is latched as the high byte and the phase toggles.
REQ-019 S_DATA, odd phase: the valid byte completes the word.
  - SRAM_we_n = 0 for exactly the next cycle, with SRAM_address = Word_count and SRAM_write_data = {high, low}.
  - Word_count increments on that same edge.
REQ-020 Write latency: one cycle from the Byte_valid of the odd byte to the write cycle. Back-to-back Byte_valid every cycle is sustained with no loss.
REQ-021 Timer: resets to 0 on every valid byte and counts while in S_HEADER or S_DATA, once at least one byte has been received since Start.
REQ-022 When the timer reaches TIMEOUT_CYCLES-1, the FSM moves to S_FLUSH if a high byte is pending, otherwise to S_DONE.
REQ-023 S_FLUSH: one write of {high, 8'h00} at Word_count, then Word_count increments and the FSM moves to S_DONE.
REQ-024 S_DONE: Done = 1 for one cycle, then S_IDLE.
REQ-025 If a word would be written with Word_count > MAX_WORD_ADDR, the write is suppressed, Overflow is set and Word_count saturates. The transfer continues until timeout.
REQ-026 If Byte_valid and the timeout condition occur in the same cycle, the byte wins and the timer restarts.
REQ-027 Start while Busy is ignored.
REQ-028 SRAM_we_n is high in every cycle that is not a write cycle.

Reset
REQ-029 Reset takes priority over all inputs and completes within one clock edge.
REQ-030 Reset values:
  - state S_IDLE, SRAM_we_n = 1
  - SRAM_address, SRAM_write_data, Word_count = 0
  - Busy, Done, Overflow = 0
  - timer, LF counter and phase cleared
REQ-031 Reset asserted mid-transfer abandons the transfer with no further write and no Done pulse.

Structure
REQ-032 The state enum and the 8'h0A line-feed constant live in the shared define_state package alongside the existing top-level states.
REQ-033 The idle timer is a separate sub-module, ppm_idle_timer (clear, enable, expired); everything else is flat.

Verification (TIMEOUT_CYCLES = 16)
REQ-034 Header "P6\n4 2\n255\n" then bytes 11 22 33 44 -> exactly two writes: addr 0 = 16'h1122, addr 1 = 16'h3344; Done 16 cycles after the last byte; Word_count = 2.
REQ-035 Same header then bytes AA BB CC, then silence -> writes addr 0 = 16'hAABB and addr 1 = 16'hCC00; Word_count = 2.
REQ-036 Byte_valid held high for 6 consecutive cycles of data 01..06 after the header -> 3 writes 0102, 0304, 0506, one cycle after each even byte.
REQ-037 MAX_WORD_ADDR = 1 with 6 data bytes -> 2 writes only; Overflow = 1; Word_count = 2; Done still pulses.
REQ-038 Reset asserted after 3 data bytes -> SRAM_we_n stays 1, all outputs return to their reset values, and no Done pulse.
REQ-039 Byte_valid arriving in the same cycle the timer hits 15 -> no Done; the timer restarts; Done follows 16 idle cycles later.
